// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared types and constants for the UART receive frame controller
package uart_rx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } rx_state_e;

   localparam int DATA_WIDTH_DEF = 8;

   localparam int PRESC_8  = 8;
   localparam int PRESC_16 = 16;
   localparam int PRESC_32 = 32;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_fsm_if.sv
// rtl/uart_rx_fsm_if.sv - line, configuration and strobe signals around the RX frame controller
interface uart_rx_fsm_if #(
   parameter int PRESC_W = 6
);

   logic               rx_in;
   logic [PRESC_W-1:0] prescale;
   logic               par_en;
   logic               par_typ;
   logic               sampled_bit;
   logic [PRESC_W-1:0] edge_cnt;
   logic               sample_en;
   logic               deser_en;
   logic               data_valid;
   logic               par_err;
   logic               stp_err;
   logic               busy;

   // master is the frame controller; slave is the line/sampler/deserializer side
   modport master (
      input  rx_in, prescale, par_en, par_typ, sampled_bit,
      output edge_cnt, sample_en, deser_en, data_valid, par_err, stp_err, busy
   );

   modport slave (
      output rx_in, prescale, par_en, par_typ, sampled_bit,
      input  edge_cnt, sample_en, deser_en, data_valid, par_err, stp_err, busy
   );

endinterface

// File: rtl/uart_rx_edge_bit_cnt.sv
// rtl/uart_rx_edge_bit_cnt.sv - oversample edge counter and bit counter for one UART frame
module uart_rx_edge_bit_cnt #(
   parameter int PRESC_W = 6,
   parameter int BIT_W   = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               clr,
   input  logic [PRESC_W-1:0] prescale_q,
   output logic [PRESC_W-1:0] edge_cnt,
   output logic [BIT_W-1:0]   bit_cnt
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         edge_cnt <= '0;
         bit_cnt  <= '0;
      end else if (clr) begin
         edge_cnt <= '0;
         bit_cnt  <= '0;
      end else if (en) begin
         if (edge_cnt == prescale_q - PRESC_W'(1)) begin
            edge_cnt <= '0;
            bit_cnt  <= bit_cnt + BIT_W'(1);
         end else begin
            edge_cnt <= edge_cnt + PRESC_W'(1);
         end
      end
   end

endmodule

// File: rtl/uart_rx_fsm.sv
// rtl/uart_rx_fsm.sv - UART RX frame controller: start detect, sampler/deserializer strobes, parity and stop checks
module uart_rx_fsm
   import uart_rx_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int PRESC_W    = 6
) (
   input  logic         clk,
   input  logic         rst,
   uart_rx_fsm_if.master bus
);

   localparam int BIT_W = $clog2(DATA_WIDTH + 1);

   rx_state_e          state;
   logic [PRESC_W-1:0] prescale_q;
   logic [PRESC_W-1:0] edge_cnt;
   logic [PRESC_W-1:0] mid;
   logic [BIT_W-1:0]   bit_cnt;
   logic               par_en_q;
   logic               par_typ_q;
   logic               bit_q;
   logic               acc;
   logic               mismatch;
   logic               dec_edge;
   logic               last_edge;
   logic               cnt_en;
   logic               cnt_clr;
   logic               sample_en_q;
   logic               deser_en_q;
   logic               data_valid_q;
   logic               par_err_q;
   logic               stp_err_q;
   logic               busy_q;

   assign mid       = prescale_q >> 1;
   assign dec_edge  = (edge_cnt == mid + PRESC_W'(2));
   assign last_edge = (edge_cnt == prescale_q - PRESC_W'(1));

   // The detection cycle counts as edge 0, so the counter starts moving in IDLE on rx_in low.
   assign cnt_en  = (state != IDLE) || !bus.rx_in;
   assign cnt_clr = (state == IDLE) ? bus.rx_in : (last_edge && (state != DATA));

   uart_rx_edge_bit_cnt #(
      .PRESC_W (PRESC_W),
      .BIT_W   (BIT_W)
   ) u_cnt (
      .clk        (clk),
      .rst        (rst),
      .en         (cnt_en),
      .clr        (cnt_clr),
      .prescale_q (prescale_q),
      .edge_cnt   (edge_cnt),
      .bit_cnt    (bit_cnt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         prescale_q   <= '0;
         par_en_q     <= 1'b0;
         par_typ_q    <= 1'b0;
         bit_q        <= 1'b0;
         acc          <= 1'b0;
         mismatch     <= 1'b0;
         sample_en_q  <= 1'b0;
         deser_en_q   <= 1'b0;
         data_valid_q <= 1'b0;
         par_err_q    <= 1'b0;
         stp_err_q    <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         data_valid_q <= 1'b0;
         par_err_q    <= 1'b0;
         stp_err_q    <= 1'b0;
         // Strobes are registered, so decode one edge early to land on the intended edge.
         sample_en_q  <= (state != IDLE) &&
                         ((edge_cnt == mid - PRESC_W'(2)) ||
                          (edge_cnt == mid - PRESC_W'(1)) ||
                          (edge_cnt == mid));
         deser_en_q   <= (state == DATA) && (edge_cnt == mid + PRESC_W'(1));
         busy_q       <= (state != IDLE) || !bus.rx_in;
         case (state)
            IDLE: begin
               if (!bus.rx_in) begin
                  state      <= START;
                  prescale_q <= bus.prescale;
                  par_en_q   <= bus.par_en;
                  par_typ_q  <= bus.par_typ;
                  mismatch   <= 1'b0;
               end
            end
            START: begin
               if (dec_edge) bit_q <= bus.sampled_bit;
               if (last_edge) begin
                  acc   <= 1'b0;
                  state <= bit_q ? IDLE : DATA;
               end
            end
            DATA: begin
               if (dec_edge) acc <= acc ^ bus.sampled_bit;
               if (last_edge && (bit_cnt == BIT_W'(DATA_WIDTH - 1)))
                  state <= par_en_q ? PARITY : STOP;
            end
            PARITY: begin
               if (dec_edge) mismatch <= bus.sampled_bit ^ acc ^ (par_typ_q == PAR_ODD);
               if (last_edge) state <= STOP;
            end
            STOP: begin
               if (dec_edge) bit_q <= bus.sampled_bit;
               if (last_edge) begin
                  state <= IDLE;
                  if (mismatch)    par_err_q    <= 1'b1;
                  else if (!bit_q) stp_err_q    <= 1'b1;
                  else             data_valid_q <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.edge_cnt   = edge_cnt;
   assign bus.sample_en  = sample_en_q;
   assign bus.deser_en   = deser_en_q;
   assign bus.data_valid = data_valid_q;
   assign bus.par_err    = par_err_q;
   assign bus.stp_err    = stp_err_q;
   assign bus.busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb/tb_uart_rx_fsm.sv - self-checking bench for uart_rx_fsm against a cycle-offset frame model
module tb_uart_rx_fsm;
   import uart_rx_pkg::*;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   uart_rx_fsm_if #(.PRESC_W(6)) u_if ();

   uart_rx_fsm #(
      .DATA_WIDTH (8),
      .PRESC_W    (6)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if.master)
   );

   int vectors     = 0;
   int miscompares = 0;

   // flags owed in the next flag cycle: {data_valid, par_err, stp_err}
   logic [2:0] pend_flags;
   logic       prev_busy;

   function automatic logic [31:0] obs();
      return {20'd0, u_if.edge_cnt, u_if.sample_en, u_if.deser_en,
              u_if.data_valid, u_if.par_err, u_if.stp_err, u_if.busy};
   endfunction

   task automatic chk(input string tag, input int k, input logic [31:0] o, input logic [31:0] e);
      vectors++;
      assert (o === e) else begin
         miscompares++;
         $error("FAIL %s k=%0d observed=%03h expected=%03h", tag, k, o, e);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycle(input string tag);
      step();
      chk(tag, 0, obs(), {20'd0, 6'd0, 1'b0, 1'b0, pend_flags, prev_busy});
      pend_flags = 3'b000;
      prev_busy  = 1'b0;
      u_if.rx_in       = 1'b1;
      u_if.sampled_bit = 1'($urandom);
   endtask

   // Cycle k counts from the detection cycle; the flag cycle (k = n*p) belongs to whatever follows.
   task automatic frame(input string tag, input int p, input bit pe, input bit pt,
                        input logic [7:0] data, input bit pflip, input bit stop_bit,
                        input int glitch_len, input int alt_presc, input int rst_at);
      int         n, mid, b, e;
      logic       bits [0:10];
      logic       rx;
      logic [2:0] exp_flags;
      bit         exp_se, exp_de, exp_busy;
      n   = (glitch_len > 0) ? 1 : (pe ? 11 : 10);
      mid = p / 2;
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[i+1] = data[i];
      bits[9]  = pe ? (^data ^ pt ^ pflip) : stop_bit;
      bits[10] = stop_bit;
      for (int k = 0; k < n * p; k++) begin
         b = k / p;
         e = k % p;
         step();
         exp_se    = (k > 0) && (e >= mid - 1) && (e <= mid + 1);
         exp_de    = (glitch_len == 0) && (b >= 1) && (b <= 8) && (e == mid + 2);
         exp_flags = (k == 0) ? pend_flags : 3'b000;
         exp_busy  = (k == 0) ? prev_busy : 1'b1;
         chk(tag, k, obs(), {20'd0, 6'(e), exp_se, exp_de, exp_flags, exp_busy});
         if (rst_at > 0 && k == rst_at) begin
            rst = 1'b1;
            #1;
            chk({tag, "_rst_out"}, k, obs(), 32'd0);
            chk({tag, "_rst_state"}, k, 32'(dut.state), 32'(IDLE));
            u_if.rx_in = 1'b1;
            step();
            step();
            rst = 1'b0;
            pend_flags = 3'b000;
            prev_busy  = 1'b0;
            return;
         end
         rx = (glitch_len > 0) ? (k >= glitch_len) : bits[b];
         u_if.rx_in       = rx;
         u_if.sampled_bit = (e == mid + 2) ? rx : 1'($urandom);
         if (k == 0) begin
            u_if.prescale = 6'(p);
            u_if.par_en   = pe;
            u_if.par_typ  = pt;
         end
         if (alt_presc > 0 && k == 2 * p) begin
            u_if.prescale = 6'(alt_presc);
            u_if.par_en   = ~pe;
         end
      end
      if (glitch_len > 0)     pend_flags = 3'b000;
      else if (pe && pflip)   pend_flags = 3'b010;
      else if (!stop_bit)     pend_flags = 3'b001;
      else                    pend_flags = 3'b100;
      prev_busy = 1'b1;
   endtask

   int presc_tab [3] = '{PRESC_8, PRESC_16, PRESC_32};

   initial begin
      rst              = 1'b1;
      u_if.rx_in       = 1'b1;
      u_if.sampled_bit = 1'b0;
      u_if.prescale    = 6'd8;
      u_if.par_en      = 1'b0;
      u_if.par_typ     = 1'b0;
      pend_flags       = 3'b000;
      prev_busy        = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_out", 0, obs(), 32'd0);
      chk("reset_state", 0, 32'(dut.state), 32'(IDLE));
      rst = 1'b0;
      idle_cycle("idle0");
      idle_cycle("idle1");

      frame("t1_a5_p8", 8, 1'b0, PAR_EVEN, 8'hA5, 1'b0, 1'b1, 0, 0, 0);
      idle_cycle("t1_flag");
      idle_cycle("t1_after");

      frame("t2_par_ok", 16, 1'b1, PAR_EVEN, 8'h3C, 1'b0, 1'b1, 0, 0, 0);
      idle_cycle("t2_ok_flag");
      frame("t2_par_bad", 16, 1'b1, PAR_EVEN, 8'h3C, 1'b1, 1'b1, 0, 0, 0);
      idle_cycle("t2_bad_flag");

      frame("t3_glitch", 8, 1'b0, PAR_EVEN, 8'h00, 1'b0, 1'b1, 3, 0, 0);
      idle_cycle("t3_back_idle");
      idle_cycle("t3_busy_low");

      frame("t4_stp_err", 16, 1'b0, PAR_EVEN, 8'h81, 1'b0, 1'b0, 0, 0, 0);
      idle_cycle("t4_flag");
      frame("t4_par_over_stp", 8, 1'b1, PAR_ODD, 8'h6D, 1'b1, 1'b0, 0, 0, 0);
      idle_cycle("t4b_flag");

      frame("t5_55_p32", 32, 1'b0, PAR_EVEN, 8'h55, 1'b0, 1'b1, 0, 8, 0);
      frame("t5_ff_p32", 32, 1'b0, PAR_EVEN, 8'hFF, 1'b0, 1'b1, 0, 0, 0);
      idle_cycle("t5_flag");

      frame("t6_rst_mid", 8, 1'b0, PAR_EVEN, 8'hC3, 1'b0, 1'b1, 0, 0, 40);
      idle_cycle("t6_post_rst");
      frame("t6_fresh", 8, 1'b0, PAR_EVEN, 8'h5A, 1'b0, 1'b1, 0, 0, 0);
      idle_cycle("t6_flag");

      for (int r = 0; r < 12; r++) begin
         frame("rand", presc_tab[$urandom_range(0, 2)], 1'($urandom), 1'($urandom),
               8'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0), 0, 0, 0);
         if ($urandom_range(0, 1) == 1) idle_cycle("rand_gap");
      end
      idle_cycle("final_flag");
      idle_cycle("final_idle");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
